// File: rtl/pcs_defs.sv
// Shared 1000BASE-X PCS definitions: truth constants, receive-alignment FSM
// encodings and a counter-width helper.
package pcs_defs;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic OK    = 1'b1;
    localparam logic FAIL  = 1'b0;

    localparam int SLIP_POSITIONS = 10;

    localparam logic [6:0] S_IDLE    = 7'b000_0001;
    localparam logic [6:0] S_RESTART = 7'b000_0010;
    localparam logic [6:0] S_SEARCH  = 7'b000_0100;
    localparam logic [6:0] S_SLIP    = 7'b000_1000;
    localparam logic [6:0] S_SETTLE  = 7'b001_0000;
    localparam logic [6:0] S_QUALIFY = 7'b010_0000;
    localparam logic [6:0] S_LINK_UP = 7'b100_0000;

    typedef enum logic [6:0] {
        ST_IDLE    = S_IDLE,
        ST_RESTART = S_RESTART,
        ST_SEARCH  = S_SEARCH,
        ST_SLIP    = S_SLIP,
        ST_SETTLE  = S_SETTLE,
        ST_QUALIFY = S_QUALIFY,
        ST_LINK_UP = S_LINK_UP
    } align_state_t;

    // Width for a counter spanning 0..p-1; a parameter of 1 still needs one bit.
    function automatic int cnt_width(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/rx_align_ctrl.sv
// Receive alignment controller: restarts Synchronization, walks the PMA slip
// offset until code-group sync appears, then debounces it into link_ok.
module rx_align_ctrl
    import pcs_defs::*;
#(
    parameter int SEARCH_CYCLES  = 64,
    parameter int SLIP_SETTLE    = 4,
    parameter int RESTART_CYCLES = 2,
    parameter int STABLE_CYCLES  = 16
) (
    input  logic       Clk,
    input  logic       mr_main_reset,
    input  logic       enable,
    input  logic       code_sync_status,
    input  logic       PUDI_indicate,
    output logic       sync_restart,
    output logic       bitslip,
    output logic [3:0] slip_pos,
    output logic       link_ok,
    output logic       align_fail,
    output logic [7:0] loss_events
);

    localparam int SEARCH_W  = cnt_width(SEARCH_CYCLES);
    localparam int SETTLE_W  = cnt_width(SLIP_SETTLE);
    localparam int RESTART_W = cnt_width(RESTART_CYCLES);
    localparam int STABLE_W  = cnt_width(STABLE_CYCLES);

    localparam logic [SEARCH_W-1:0]  SEARCH_LAST  = SEARCH_W'(SEARCH_CYCLES - 1);
    localparam logic [SETTLE_W-1:0]  SETTLE_LAST  = SETTLE_W'(SLIP_SETTLE - 1);
    localparam logic [RESTART_W-1:0] RESTART_LAST = RESTART_W'(RESTART_CYCLES - 1);
    localparam logic [STABLE_W-1:0]  STABLE_LAST  = STABLE_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]           SLIP_LAST    = 4'(SLIP_POSITIONS - 1);

    align_state_t         r_state;
    align_state_t         w_next_state;
    logic [RESTART_W-1:0] r_restart_cnt;
    logic [SETTLE_W-1:0]  r_settle_cnt;
    logic [3:0]           r_slip_pos;
    logic [3:0]           w_slip_next;
    logic                 r_sync_restart;
    logic                 r_bitslip;
    logic                 r_link_ok;
    logic                 r_align_fail;

    logic [SEARCH_W-1:0]  w_search_cnt;
    logic [STABLE_W-1:0]  w_stable_cnt;
    logic [7:0]           w_loss_cnt;
    logic                 w_search_inc;
    logic                 w_search_clr;
    logic                 w_stable_inc;
    logic                 w_loss_inc;

    always_comb begin
        // NOTE: default first so no path through this block leaves it unassigned (no latch).
        w_next_state = r_state;
        if (enable != TRUE) begin
            w_next_state = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE:    w_next_state = ST_RESTART;
                ST_RESTART: if (r_restart_cnt == RESTART_LAST) w_next_state = ST_SEARCH;
                ST_SEARCH: begin
                    // Sync found outranks a timeout on the same cycle.
                    if (code_sync_status == OK)
                        w_next_state = ST_QUALIFY;
                    else if (PUDI_indicate && (w_search_cnt == SEARCH_LAST))
                        w_next_state = ST_SLIP;
                end
                ST_SLIP:    w_next_state = ST_SETTLE;
                ST_SETTLE:  if (r_settle_cnt == SETTLE_LAST) w_next_state = ST_RESTART;
                ST_QUALIFY: begin
                    if (code_sync_status != OK)
                        w_next_state = ST_SEARCH;
                    else if (w_stable_cnt == STABLE_LAST)
                        w_next_state = ST_LINK_UP;
                end
                ST_LINK_UP: if (code_sync_status != OK) w_next_state = ST_SEARCH;
                default:    w_next_state = ST_IDLE;
            endcase
        end
    end

    assign w_slip_next  = (r_slip_pos == SLIP_LAST) ? 4'd0 : r_slip_pos + 4'd1;

    // Timers restart whenever their state is (re)entered or left.
    assign w_search_inc = (r_state == ST_SEARCH) && (w_next_state == ST_SEARCH) && PUDI_indicate;
    assign w_search_clr = (r_state != ST_SEARCH) || (w_next_state != ST_SEARCH);
    assign w_stable_inc = (r_state == ST_QUALIFY) && (w_next_state == ST_QUALIFY);
    assign w_loss_inc   = (r_state == ST_LINK_UP) && (w_next_state == ST_SEARCH);

    sat_counter #(.WIDTH(SEARCH_W)) u_search_timer (
        .clk     (Clk),
        .rst     (mr_main_reset),
        .i_clear (w_search_clr),
        .i_inc   (w_search_inc),
        .o_count (w_search_cnt)
    );

    sat_counter #(.WIDTH(STABLE_W)) u_stable_timer (
        .clk     (Clk),
        .rst     (mr_main_reset),
        .i_clear (!w_stable_inc),
        .i_inc   (w_stable_inc),
        .o_count (w_stable_cnt)
    );

    sat_counter #(.WIDTH(8)) u_loss_events (
        .clk     (Clk),
        .rst     (mr_main_reset),
        .i_clear (1'b0),
        .i_inc   (w_loss_inc),
        .o_count (w_loss_cnt)
    );

    always_ff @(posedge Clk or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            r_state        <= ST_IDLE;
            r_restart_cnt  <= '0;
            r_settle_cnt   <= '0;
            r_slip_pos     <= '0;
            r_sync_restart <= FALSE;
            r_bitslip      <= FALSE;
            r_link_ok      <= FALSE;
            r_align_fail   <= FALSE;
        end else begin
            r_state        <= w_next_state;
            r_sync_restart <= (w_next_state == ST_RESTART);
            r_bitslip      <= (w_next_state == ST_SLIP);
            r_link_ok      <= (w_next_state == ST_LINK_UP);
            r_restart_cnt  <= ((r_state == ST_RESTART) && (w_next_state == ST_RESTART))
                              ? r_restart_cnt + RESTART_W'(1) : '0;
            r_settle_cnt   <= ((r_state == ST_SETTLE) && (w_next_state == ST_SETTLE))
                              ? r_settle_cnt + SETTLE_W'(1) : '0;
            if (w_next_state == ST_SLIP) begin
                r_slip_pos <= w_slip_next;
                if (r_slip_pos == SLIP_LAST)
                    r_align_fail <= TRUE;
            end else if (w_next_state == ST_LINK_UP) begin
                r_align_fail <= FALSE;
            end
        end
    end

    assign sync_restart = r_sync_restart;
    assign bitslip      = r_bitslip;
    assign slip_pos     = r_slip_pos;
    assign link_ok      = r_link_ok;
    assign align_fail   = r_align_fail;
    assign loss_events  = w_loss_cnt;

endmodule

// File: tb/tb_rx_align_ctrl.sv
// Directed bench for rx_align_ctrl: a short vector table for the FSM entry
// paths, then hand sequences for slip timing, qualification, saturation and reset.
module tb_rx_align_ctrl;

    logic       Clk = 1'b0;
    logic       mr_main_reset;
    logic       enable;
    logic       code_sync_status;
    logic       PUDI_indicate;
    logic       sync_restart;
    logic       bitslip;
    logic [3:0] slip_pos;
    logic       link_ok;
    logic       align_fail;
    logic [7:0] loss_events;

    int n_vec  = 0;
    int n_err  = 0;
    int n_viol = 0;
    int n_slip = 0;
    logic prev_bitslip = 1'b0;

    // Output bundle: {sync_restart, bitslip, link_ok, align_fail, slip_pos, loss_events}
    typedef struct {
        logic        en;
        logic        st;
        logic        pudi;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[11];

    rx_align_ctrl dut (
        .Clk              (Clk),
        .mr_main_reset    (mr_main_reset),
        .enable           (enable),
        .code_sync_status (code_sync_status),
        .PUDI_indicate    (PUDI_indicate),
        .sync_restart     (sync_restart),
        .bitslip          (bitslip),
        .slip_pos         (slip_pos),
        .link_ok          (link_ok),
        .align_fail       (align_fail),
        .loss_events      (loss_events)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] outs();
        return {sync_restart, bitslip, link_ok, align_fail, slip_pos, loss_events};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply inputs, clock once, settle 1 time unit past the edge, and watch bitslip rules.
    task automatic step(input logic en, input logic st, input logic pudi);
        enable           = en;
        code_sync_status = st;
        PUDI_indicate    = pudi;
        @(posedge Clk);
        #1;
        if (bitslip && sync_restart) n_viol++;
        if (bitslip && prev_bitslip) n_viol++;
        if (bitslip) n_slip++;
        prev_bitslip = bitslip;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int last_cyc;
        int slips;
        int restart_hi;
        int n;
        int slip_mark;
        int d_err;
        int exp_loss;

        vecs[0]  = '{1'b1, 1'b0, 1'b1, 16'h8000};  // IDLE -> RESTART
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 16'h8000};  // RESTART second cycle
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 16'h0000};  // -> SEARCH
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 16'h0000};  // -> QUALIFY
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 16'h0000};  // drop -> SEARCH
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 16'h0000};  // -> QUALIFY without PUDI
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 16'h0000};  // enable low -> IDLE
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 16'h8000};  // -> RESTART, status ignored
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000};  // abort RESTART -> IDLE
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 16'h0000};  // IDLE holds
        vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h8000};  // -> RESTART

        mr_main_reset    = 1'b1;
        enable           = 1'b0;
        code_sync_status = 1'b0;
        PUDI_indicate    = 1'b0;
        #12;
        check("reset_state", 32'(outs()), 32'h0);
        @(posedge Clk);
        #1;
        mr_main_reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].en, vecs[i].st, vecs[i].pudi);
            check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end

        // Slip timing and rotation: 11 slips from a fresh reset.
        mr_main_reset = 1'b1;
        #1;
        mr_main_reset = 1'b0;
        slips      = 0;
        restart_hi = 0;
        last_cyc   = 0;
        for (cyc = 0; cyc < 1000; cyc++) begin
            step(1'b1, 1'b0, 1'b1);
            if (sync_restart && slips == 0) restart_hi++;
            if (bitslip) begin
                slips++;
                if (slips == 1) check("first_slip_cycle", 32'(cyc), 32'd66);
                else            check("slip_period", 32'(cyc - last_cyc), 32'd71);
                check($sformatf("slip_pos_after_%0d", slips), 32'(slip_pos), 32'(slips % 10));
                check($sformatf("align_fail_after_%0d", slips), 32'(align_fail), 32'(slips >= 10));
                last_cyc = cyc;
                if (slips == 11) break;
            end
        end
        if (slips < 11) check("slip_budget", 32'(slips), 32'd11);
        check("restart_high_cycles", 32'(restart_hi), 32'd2);

        // SETTLE(4) + RESTART(2) + entry into SEARCH, then qualify for 17 samples.
        repeat (7) step(1'b1, 1'b0, 1'b1);
        repeat (16) step(1'b1, 1'b1, 1'b1);
        check("link_ok_before_17th", 32'(link_ok), 32'd0);
        check("align_fail_before_link", 32'(align_fail), 32'd1);
        step(1'b1, 1'b1, 1'b1);
        check("link_ok_at_17th", 32'(link_ok), 32'd1);
        check("align_fail_cleared", 32'(align_fail), 32'd0);

        // Loss from LINK_UP, then a partial qualify that drops after 8 highs.
        step(1'b1, 1'b0, 1'b1);
        check("link_ok_falls", 32'(link_ok), 32'd0);
        check("loss_after_first_drop", 32'(loss_events), 32'd1);
        repeat (30) step(1'b1, 1'b0, 1'b1);
        slip_mark = n_slip;
        repeat (8) step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check("qualify_drop_link_ok", 32'(link_ok), 32'd0);
        check("qualify_drop_loss", 32'(loss_events), 32'd1);
        // Without PUDI the search timer must not move.
        repeat (20) step(1'b1, 1'b0, 1'b0);
        check("qualify_drop_no_slip", 32'(n_slip - slip_mark), 32'd0);
        for (n = 1; n <= 200; n++) begin
            step(1'b1, 1'b0, 1'b1);
            if (bitslip) break;
        end
        check("search_timer_cleared", 32'(n), 32'd64);

        // Requalify, then enable and status fall together in LINK_UP.
        repeat (7) step(1'b1, 1'b0, 1'b1);
        repeat (17) step(1'b1, 1'b1, 1'b1);
        check("link_ok_requalified", 32'(link_ok), 32'd1);
        step(1'b0, 1'b0, 1'b1);
        check("enable_drop_outputs", 32'(outs()), 32'h0201);
        step(1'b1, 1'b0, 1'b1);
        check("reenable_restart", 32'(outs()), 32'h8201);

        // One RESTART cycle left, enter SEARCH, qualify, then 300 one-cycle drops.
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        repeat (17) step(1'b1, 1'b1, 1'b1);
        d_err = 0;
        for (int i = 0; i < 300; i++) begin
            exp_loss = (i + 2 > 255) ? 255 : i + 2;
            step(1'b1, 1'b0, 1'b1);
            if (link_ok !== 1'b0 || loss_events !== 8'(exp_loss)) d_err++;
            repeat (17) step(1'b1, 1'b1, 1'b1);
            if (link_ok !== 1'b1) d_err++;
        end
        check("sat_walk_errors", 32'(d_err), 32'd0);
        check("loss_saturated", 32'(loss_events), 32'd255);

        // Reach SETTLE, then reset asynchronously between edges.
        step(1'b1, 1'b0, 1'b1);
        for (n = 1; n <= 200; n++) begin
            step(1'b1, 1'b0, 1'b1);
            if (bitslip) break;
        end
        check("slip_before_settle", 32'(n), 32'd64);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        #2;
        mr_main_reset = 1'b1;
        #1;
        check("async_reset_outputs", 32'(outs()), 32'h0);
        mr_main_reset = 1'b0;
        step(1'b1, 1'b0, 1'b1);
        check("post_reset_restart", 32'(outs()), 32'h8000);

        check("bitslip_rule_violations", 32'(n_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
